// File: rtl/irq_controller.sv
// Interrupt controller: synchronised sources latch into pending, lowest enabled index requests; registered irq/id/vector, 1-cycle HOLDOFF after each ack.
// Latency src->irq 4 edges (3 with IRQ_CTRL_LEVEL_EN: pending follows synchronised level, ack does not clear); no backpressure, reset_irq outside ASSERT ignored.
module irq_controller #(
    parameter int          NUM_SOURCES = 4,
    parameter logic [15:0] VECTOR_BASE = 16'h0100
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irq_src,
    input  logic                   mask_write,
    input  logic [NUM_SOURCES-1:0] mask_data,
    input  logic                   reset_irq,
    output logic                   irq,
    output logic [15:0]            irq_vector,
    output logic [3:0]             irq_id,
    output logic [NUM_SOURCES-1:0] pending,
    output logic [NUM_SOURCES-1:0] mask
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_SOURCES-1:0] s1_q, s1_d;
    logic [NUM_SOURCES-1:0] s2_q, s2_d;
    logic [NUM_SOURCES-1:0] mask_q, mask_d;
    logic                   irq_q, irq_d;
    logic [3:0]             irq_id_q, irq_id_d;
    logic [15:0]            irq_vector_q, irq_vector_d;
    logic [NUM_SOURCES-1:0] pend_vec;
    logic [NUM_SOURCES-1:0] eligible;
    logic [3:0]             win_id;

    always_comb begin
        s1_d   = irq_src;
        s2_d   = s1_q;
        mask_d = mask_write ? mask_data : mask_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            mask_q <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            mask_q <= mask_d;
        end
    end

`ifdef IRQ_CTRL_LEVEL_EN
    assign pend_vec = s2_q;
`else
    logic [NUM_SOURCES-1:0] s3_q, s3_d;
    logic [NUM_SOURCES-1:0] pending_q, pending_d;
    logic [NUM_SOURCES-1:0] evt, clr;
    logic                   ack;

    assign ack = (state_q == ST_ASSERT) && reset_irq;

    // A fresh edge in the ack cycle must survive, so set is OR-ed in after clear.
    always_comb begin
        s3_d = s2_q;
        evt  = s2_q & ~s3_q;
        clr  = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            clr[i] = ack && (irq_id_q == 4'(i));
        end
        pending_d = (pending_q & ~clr) | evt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s3_q      <= '0;
            pending_q <= '0;
        end else begin
            s3_q      <= s3_d;
            pending_q <= pending_d;
        end
    end

    assign pend_vec = pending_q;
`endif

    // Descending scan so the lowest eligible index is the final assignment.
    always_comb begin
        eligible = pend_vec & mask_q;
        win_id   = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id = 4'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        irq_d        = irq_q;
        irq_id_d     = irq_id_q;
        irq_vector_d = irq_vector_q;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    state_d      = ST_ASSERT;
                    irq_d        = 1'b1;
                    irq_id_d     = win_id;
                    irq_vector_d = VECTOR_BASE + {10'd0, win_id, 2'b00};
                end
            end
            ST_ASSERT: begin
                if (reset_irq) begin
                    state_d = ST_HOLDOFF;
                    irq_d   = 1'b0;
                end
            end
            ST_HOLDOFF: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            irq_q        <= 1'b0;
            irq_id_q     <= '0;
            irq_vector_q <= VECTOR_BASE;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            irq_id_q     <= irq_id_d;
            irq_vector_q <= irq_vector_d;
        end
    end

    assign irq        = irq_q;
    assign irq_id     = irq_id_q;
    assign irq_vector = irq_vector_q;
    assign pending    = pend_vec;
    assign mask       = mask_q;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench: reference model pushes expected grants, monitor pops on each irq rise.
`timescale 1ns/1ps
module tb_irq_controller;
    localparam int          N     = 4;
    localparam logic [15:0] VBASE = 16'h0100;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  irq_src = '0;
    logic          mask_write = 1'b0;
    logic [N-1:0]  mask_data = '0;
    logic          reset_irq = 1'b0;
    logic          irq;
    logic [15:0]   irq_vector;
    logic [3:0]    irq_id;
    logic [N-1:0]  pending;
    logic [N-1:0]  mask;

    irq_controller #(.NUM_SOURCES(N), .VECTOR_BASE(VBASE)) dut (
        .clock      (clock),
        .reset      (reset),
        .irq_src    (irq_src),
        .mask_write (mask_write),
        .mask_data  (mask_data),
        .reset_irq  (reset_irq),
        .irq        (irq),
        .irq_vector (irq_vector),
        .irq_id     (irq_id),
        .pending    (pending),
        .mask       (mask)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          id;
        logic [15:0] vec;
        int          cyc;
    } grant_t;

    grant_t       exp_q[$];
    logic [N-1:0] d1 = '0, d2 = '0, d3 = '0;
    logic [N-1:0] m_pend = '0, m_mask = '0;
    int           m_serving = -1;
    bit           m_quiet = 1'b0;
    int           cyc = 0;
    logic         irq_prev = 1'b0;
    int           cur_id = 0;

    function automatic int first_set(logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Reference: sampled-input delay line, pending bits, serve/quiet bookkeeping.
    initial begin : model
        logic [N-1:0] ev, clr, elig;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                d1 = '0; d2 = '0; d3 = '0;
                m_pend = '0; m_mask = '0;
                m_serving = -1; m_quiet = 1'b0;
                exp_q.delete();
            end else begin
                cyc++;
                ev   = d2 & ~d3;
                clr  = '0;
                elig = m_pend & m_mask;
                if (m_serving >= 0) begin
                    if (reset_irq) begin
                        clr[m_serving] = 1'b1;
                        m_serving = -1;
                        m_quiet = 1'b1;
                    end
                end else if (m_quiet) begin
                    m_quiet = 1'b0;
                end else if (elig != '0) begin
                    m_serving = first_set(elig);
                    exp_q.push_back('{m_serving, 16'(32'(VBASE) + 4 * m_serving), cyc});
                end
                m_pend = (m_pend & ~clr) | ev;
                if (mask_write) m_mask = mask_data;
                d3 = d2; d2 = d1; d1 = irq_src;
            end
        end
    end

    initial begin : monitor
        grant_t g;
        forever begin
            @(negedge clock);
            if (!reset) begin
                chk("irq_level", 32'(irq), 32'(m_serving >= 0));
                if (irq && !irq_prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL grant_unexpected: irq rose with id %0d, none expected", irq_id);
                    end else begin
                        g = exp_q.pop_front();
                        cur_id = g.id;
                        chk("grant_id", 32'(irq_id), g.id);
                        chk("grant_vector", 32'(irq_vector), 32'(g.vec));
                        chk("grant_cycle", cyc, g.cyc);
                    end
                end else if (irq) begin
                    chk("held_id", 32'(irq_id), cur_id);
                end
                chk("pending", 32'(pending), 32'(m_pend));
                chk("mask", 32'(mask), 32'(m_mask));
            end
            irq_prev = irq;
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic wmask(logic [N-1:0] m);
        mask_write = 1'b1;
        mask_data  = m;
        tick();
        mask_write = 1'b0;
    endtask

    task automatic ack();
        reset_irq = 1'b1;
        tick();
        reset_irq = 1'b0;
    endtask

    task automatic wait_irq(string name);
        int n = 0;
        while (!irq && n < 20) begin
            tick();
            n++;
        end
        if (!irq) begin
            checks++;
            errors++;
            $display("FAIL %s: irq got 0 expected 1 within 20 cycles", name);
        end
    endtask

    initial begin : stim
        tick(2);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_mask", 32'(mask), 0);
        chk("rst_vector", 32'(irq_vector), 32'h0100);
        chk("rst_id", 32'(irq_id), 0);
        reset = 1'b0;
        tick();

        // single source
        wmask(4'b0100);
        irq_src[2] = 1'b1; tick(2); irq_src[2] = 1'b0;
        wait_irq("single_wait");
        chk("single_id", 32'(irq_id), 2);
        chk("single_vec", 32'(irq_vector), 32'h0108);
        ack();
        chk("single_ack_irq", 32'(irq), 0);
        chk("single_ack_pend2", 32'(pending[2]), 0);
        tick(2);

        // priority
        wmask(4'b1111);
        irq_src = 4'b1010; tick(2); irq_src = '0;
        wait_irq("prio_wait");
        chk("prio_id1", 32'(irq_id), 1);
        chk("prio_vec1", 32'(irq_vector), 32'h0104);
        ack();
        chk("prio_holdoff", 32'(irq), 0);
        tick();
        chk("prio_idle", 32'(irq), 0);
        tick();
        chk("prio_irq3", 32'(irq), 1);
        chk("prio_id3", 32'(irq_id), 3);
        chk("prio_vec3", 32'(irq_vector), 32'h010C);
        ack();
        tick(2);

        // masking and spurious ack
        wmask(4'b0000);
        irq_src[0] = 1'b1; tick(2); irq_src[0] = 1'b0; tick(4);
        chk("mask_irq_low", 32'(irq), 0);
        chk("mask_pend0", 32'(pending[0]), 1);
        ack();
        chk("spur_pend0", 32'(pending[0]), 1);
        chk("spur_irq", 32'(irq), 0);
        wmask(4'b0001);
        chk("unmask_not_yet", 32'(irq), 0);
        tick();
        chk("unmask_irq", 32'(irq), 1);
        chk("unmask_id", 32'(irq_id), 0);
        chk("unmask_vec", 32'(irq_vector), 32'h0100);
        ack();
        tick(2);

        // ack / new-edge collision
        wmask(4'b0100);
        irq_src[2] = 1'b1; tick(2); irq_src[2] = 1'b0;
        wait_irq("coll_wait");
        tick(2);
        irq_src[2] = 1'b1;
        tick(2);
        reset_irq = 1'b1;
        tick();
        reset_irq = 1'b0;
        irq_src[2] = 1'b0;
        chk("coll_pend2", 32'(pending[2]), 1);
        chk("coll_irq_low", 32'(irq), 0);
        tick(2);
        chk("coll_rerequest", 32'(irq), 1);
        chk("coll_id", 32'(irq_id), 2);

        // async reset while asserting
        #2 reset = 1'b1;
        #1;
        chk("midrst_irq", 32'(irq), 0);
        chk("midrst_pending", 32'(pending), 0);
        chk("midrst_mask", 32'(mask), 0);
        chk("midrst_vector", 32'(irq_vector), 32'h0100);
        tick();
        reset = 1'b0;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
            end
            mask_write = ($urandom_range(0, 15) == 0);
            mask_data  = 4'($urandom_range(0, 15));
            reset_irq  = irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 reset = 1'b1;
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        mask_write = 1'b0;
        reset_irq  = 1'b0;
        irq_src    = '0;
        tick(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller upstream of the CPU control path. Synchronises up to `NUM_SOURCES` external interrupt lines and latches their events into pending bits gated by a software mask. It selects the highest-priority enabled source and drives a single `irq` request plus a 16-bit handler vector into the control path. It clears the serviced source when the control path acknowledges via `reset_irq`.

## Interface
Parameters:
- `NUM_SOURCES`, 4, number of interrupt inputs (1..16)
- `VECTOR_BASE`, 16'h0100, handler address of source 0; source i vectors to `VECTOR_BASE + 4*i`

Ports:
- `clock`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `irq_src`  in  NUM_SOURCES  raw external interrupt lines, asynchronous to `clock`
- `mask_write`  in  1  load `mask_data` into mask register this cycle
- `mask_data`  in  NUM_SOURCES  new mask value; bit i = 1 enables source i
- `reset_irq`  in  1  acknowledge from control path (one-cycle pulse)
- `irq`  out  1  interrupt request to control path
- `irq_vector`  out  16  handler PC, valid while `irq` = 1
- `irq_id`  out  4  index of source being requested, valid while `irq` = 1
- `pending`  out  NUM_SOURCES  raw pending bits (status readback)
- `mask`  out  NUM_SOURCES  current mask register

## Operation
- Each `irq_src[i]` passes through two synchroniser flops (s1, s2), then a history flop s3; event_i = s2 & ~s3.
- pending[i] set on event_i; cleared only by acknowledge of source i. Set wins over clear in the same cycle.
- Masked sources still latch pending; they request once unmasked.
- Eligible = pending & mask. Priority: lowest index wins.
- States:
  - IDLE: `irq` = 0. If eligible != 0, latch winner into `irq_id`, compute vector, go to ASSERT.
  - ASSERT: `irq` = 1; `irq_id`/`irq_vector` frozen. On `reset_irq` = 1, clear pending[irq_id] (unless a new event on the same source coincides) and go to HOLDOFF.
  - HOLDOFF: `irq` = 0 for exactly one cycle, then go to IDLE. This guarantees the control path sees a low before the next request.
- `reset_irq` outside ASSERT is ignored.
- A mask write during ASSERT updates `mask` but does not withdraw the request or change the latched id/vector.
- Vector arithmetic is 16-bit, `VECTOR_BASE + {irq_id, 2'b00}`, wrapping modulo 2^16.
- Reset values: state IDLE, s1/s2/s3 = 0, pending = 0, mask = 0 (all disabled), `irq` = 0, `irq_id` = 0, `irq_vector` = `VECTOR_BASE`.
- Reset mid-operation, including in ASSERT, drops `irq` immediately and discards all pending events.

## Timing
- Latency: `irq_src[i]` rises before clock edge k. s2 = 1 after k+1, pending set at k+2, ASSERT entered at k+3. `irq` is high from k+3 (4 edges), source enabled and controller idle.
- `irq`, `irq_id`, `irq_vector` are registered outputs; no combinational path from any input.
- Ack at edge a: `irq` low after a, HOLDOFF during a..a+1, IDLE at a+1. If anything is eligible, the next `irq` rises after edge a+2.
- Mask write takes effect on the next edge; an IDLE decision uses the mask value registered at that edge.
- Input pulses shorter than one clock period may be missed (edge mode).

## Configuration
- `IRQ_CTRL_LEVEL_EN` defined: level-triggered mode. pending[i] = s2 directly, with no latching and no edge detection. Acknowledge does not clear it; the source must deassert before HOLDOFF ends, otherwise it re-requests. Latency is 1 edge shorter: `irq` high after k+2.
- Undefined (default): edge-triggered latching behaviour as described above.

## Test plan
- Reset state: assert `reset` mid-ASSERT → `irq` = 0, `pending` = 0, `mask` = 0, `irq_vector` = 16'h0100 immediately.
- Single source: mask = 4'b0100, pulse `irq_src[2]` → `irq` high 4 edges later, `irq_id` = 2, `irq_vector` = 16'h0108; `reset_irq` pulse → `irq` low, `pending[2]` = 0.
- Priority: sources 1 and 3 fire same cycle, mask = 4'b1111 → id 1 served first (vector 16'h0104). After ack, one HOLDOFF cycle, then id 3 (vector 16'h010C).
- Masking: mask = 0, pulse source 0 → `irq` stays 0, `pending[0]` = 1; write mask = 4'b0001 → `irq` rises 1 edge after the write.
- Ack/edge collision: new rising event on source 2 arrives at the edge its ack is taken → `pending[2]` remains 1, source 2 re-requested after HOLDOFF.
- Spurious ack: `reset_irq` pulsed in IDLE with source 0 pending but masked → no state change, `pending[0]` stays 1.
